// File: rtl/score_scan_mux.sv
// Scoreboard front end: saturates two binary scores, converts them to BCD by repeated subtraction,
// and scans the four digits out as {en, num}. Define LEADING_ZERO_BLANK_EN to show a dash for zero tens.
module score_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_SCORE   = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] score_l,
    input  logic [6:0] score_r,
    input  logic       score_upd,
    output logic       busy,
    output logic [1:0] en,
    output logic [3:0] num
);

    typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, COMMIT} state_t;

    localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]      MAX_S   = 7'(MAX_SCORE);

    state_t           state_q, state_d;
    logic [6:0]       rem_l_q, rem_l_d, rem_r_q, rem_r_d;
    logic [3:0]       tens_l_q, tens_l_d, tens_r_q, tens_r_d;
    logic [6:0]       hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic             pending_q, pending_d;
    logic [3:0][3:0]  disp_q, disp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       en_q, en_d;
    logic [3:0]       num_q, num_d;

    function automatic logic [6:0] sat(input logic [6:0] s);
        return (s > MAX_S) ? MAX_S : s;
    endfunction

    always_comb begin
        state_d   = state_q;
        rem_l_d   = rem_l_q;
        rem_r_d   = rem_r_q;
        tens_l_d  = tens_l_q;
        tens_r_d  = tens_r_q;
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
        pending_d = pending_q;
        disp_d    = disp_q;

        // A strobe mid-conversion is parked; the newest one wins.
        if (score_upd && (state_q == CONV_L || state_q == CONV_R)) begin
            hold_l_d  = score_l;
            hold_r_d  = score_r;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (score_upd) begin
                    rem_l_d  = sat(score_l);
                    rem_r_d  = sat(score_r);
                    tens_l_d = 4'd0;
                    tens_r_d = 4'd0;
                    state_d  = CONV_L;
                end
            end
            CONV_L: begin
                if (rem_l_q >= 7'd10) begin
                    rem_l_d  = rem_l_q - 7'd10;
                    tens_l_d = tens_l_q + 4'd1;
                end else begin
                    state_d = CONV_R;
                end
            end
            CONV_R: begin
                if (rem_r_q >= 7'd10) begin
                    rem_r_d  = rem_r_q - 7'd10;
                    tens_r_d = tens_r_q + 4'd1;
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                disp_d = {tens_l_q, rem_l_q[3:0], tens_r_q, rem_r_q[3:0]};
                // A strobe landing on this very cycle is newer than anything held.
                if (score_upd) begin
                    rem_l_d   = sat(score_l);
                    rem_r_d   = sat(score_r);
                    tens_l_d  = 4'd0;
                    tens_r_d  = 4'd0;
                    pending_d = 1'b0;
                    state_d   = CONV_L;
                end else if (pending_q) begin
                    rem_l_d   = sat(hold_l_q);
                    rem_r_d   = sat(hold_r_q);
                    tens_l_d  = 4'd0;
                    tens_r_d  = 4'd0;
                    pending_d = 1'b0;
                    state_d   = CONV_L;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        en_d  = en_q;
        num_d = num_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            en_d  = en_q + 2'd1;
            num_d = disp_q[en_d];
`ifdef LEADING_ZERO_BLANK_EN
            if (en_d[0] && disp_q[en_d] == 4'd0) begin
                num_d = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_l_q   <= '0;
            rem_r_q   <= '0;
            tens_l_q  <= '0;
            tens_r_q  <= '0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            pending_q <= 1'b0;
            disp_q    <= '0;
            cnt_q     <= '0;
            en_q      <= '0;
            num_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_l_q   <= rem_l_d;
            rem_r_q   <= rem_r_d;
            tens_l_q  <= tens_l_d;
            tens_r_q  <= tens_r_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            pending_q <= pending_d;
            disp_q    <= disp_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            num_q     <= num_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign en   = en_q;
    assign num  = num_q;

endmodule

// File: tb/tb_score_scan_mux.sv
// Scoreboard bench for score_scan_mux with REFRESH_DIV=4: expected busy lengths and digit frames
// are queued by the stimulus and checked by an independent monitor.
module tb_score_scan_mux;

    logic       clk;
    logic       rst_n;
    logic [6:0] score_l;
    logic [6:0] score_r;
    logic       score_upd;
    logic       busy;
    logic [1:0] en;
    logic [3:0] num;

    int total = 0;
    int bad   = 0;

    int          busy_q[$];
    logic [15:0] frame_q[$];
    logic [15:0] cur_frame;
    int          left = 0;
    int          run = 0;
    logic        prev_busy = 0;

    int         mcnt = 0;
    logic [1:0] men = 0;
    logic       slot_evt = 0;

    score_scan_mux #(.REFRESH_DIV(4), .MAX_SCORE(99)) dut (
        .clk(clk), .rst_n(rst_n), .score_l(score_l), .score_r(score_r),
        .score_upd(score_upd), .busy(busy), .en(en), .num(num)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_digit(input logic [15:0] f, input logic [1:0] e);
        logic [3:0] d;
        d = f[int'(e)*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (e[0] && d == 4'd0) d = 4'hF;
`endif
        return int'(d);
    endfunction

    // Reference slot sequencer: en advances every 4 clocks after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt = 0;
            men = 0;
            slot_evt = 0;
        end else if (mcnt == 3) begin
            mcnt = 0;
            men = men + 2'd1;
            slot_evt = 1;
        end else begin
            mcnt = mcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
            prev_busy = 0;
            left = 0;
        end else begin
            if (busy) begin
                run++;
            end else if (prev_busy) begin
                if (busy_q.size() > 0) chk("busy_len", run, busy_q.pop_front());
                run = 0;
            end
            prev_busy = busy;
            if (slot_evt) begin
                slot_evt = 0;
                chk("en_step", int'(en), int'(men));
                if (left == 0 && frame_q.size() > 0) begin
                    cur_frame = frame_q.pop_front();
                    left = 4;
                end
                if (left > 0) begin
                    chk($sformatf("num_en%0d", men), int'(num), exp_digit(cur_frame, men));
                    left--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            tick();
            if (!busy) break;
        end
        chk("idle_timeout", int'(busy), 0);
        tick();
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_q.size() == 0 && left == 0) break;
        end
        chk("frame_timeout", left + frame_q.size(), 0);
    endtask

    task automatic run_score(input logic [6:0] l, input logic [6:0] r, input int blen,
                             input logic [15:0] frame);
        busy_q.push_back(blen);
        score_l = l;
        score_r = r;
        score_upd = 1;
        tick();
        score_upd = 0;
        wait_idle();
        frame_q.push_back(frame);
        wait_frame();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"}, int'(en), 0);
        chk({tag, "_num"}, int'(num), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        rst_n = 0;
        score_l = 0;
        score_r = 0;
        score_upd = 0;
        repeat (3) tick();
        chk_reset("por");

        // Reset mid-slot, then watch en cycle from zero.
        rst_n = 1;
        repeat (6) tick();
        rst_n = 0;
        #1;
        chk_reset("midslot");
        tick();
        rst_n = 1;
        frame_q.push_back(16'h0000);
        wait_frame();

        run_score(7'd57, 7'd3, 8, 16'h5703);
        run_score(7'd120, 7'd99, 21, 16'h9999);

        // Second strobe while the first conversion is still running.
        busy_q.push_back(12);
        score_l = 7'd10;
        score_r = 7'd10;
        score_upd = 1;
        tick();
        score_upd = 0;
        tick();
        tick();
        score_l = 7'd42;
        score_r = 7'd8;
        score_upd = 1;
        tick();
        score_upd = 0;
        score_l = 7'd0;
        score_r = 7'd0;
        wait_idle();
        frame_q.push_back(16'h4208);
        wait_frame();

        // Reset during CONV_L abandons the conversion and clears the display.
        score_l = 7'd99;
        score_r = 7'd99;
        score_upd = 1;
        tick();
        score_upd = 0;
        tick();
        tick();
        rst_n = 0;
        #1;
        chk_reset("conv_rst");
        tick();
        rst_n = 1;
        frame_q.push_back(16'h0000);
        wait_frame();
        run_score(7'd64, 7'd15, 10, 16'h6415);

        run_score(7'd5, 7'd0, 3, 16'h0500);

        chk("busy_q_drained", busy_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
